comp_serial_nbit: RTL and testbench

Sequential N-bit magnitude comparator. It processes two operand bits per clock, LSB slice first, using one 2-bit comparator cell. A higher slice that differs overrides the result accumulated so far. It sits in the ALU compare path as the multi-cycle, area-lean alternative to a fully unrolled comparator chain, and it exposes a start/done handshake to the ALU control sequencer.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/comp_cell_2bit.sv | 14 +
 rtl/comp_serial_nbit.sv | 125 ++++++++++++
 tb/tb_comp_serial_nbit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU compare-path definitions: FSM encoding, result constants and
// index sizing for the serial magnitude comparator.
package alu_pkg;

   typedef enum logic [1:0] {
      CMP_IDLE = 2'd0,
      CMP_RUN  = 2'd1,
      CMP_DONE = 2'd2
   } cmp_state_e;

   // {eq, lt, gt}
   localparam logic [2:0] RES_RST  = 3'b000;
   localparam logic [2:0] ACC_INIT = 3'b100;

   // Slice index width: clog2(n), never less than one bit.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/comp_cell_2bit.sv
// Combinational 2-bit unsigned magnitude compare cell.
module comp_cell_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       eq,
   output logic       lt,
   output logic       gt
);

   assign eq = (a == b);
   assign lt = (a <  b);
   assign gt = (a >  b);

endmodule

// File: rtl/comp_serial_nbit.sv
// Serial N-bit magnitude comparator: one 2-bit slice per clock, LSB first,
// with a start/busy/done handshake toward the ALU sequencer.
//
// state    | meaning
// CMP_IDLE | waiting for start; result registers hold last outcome
// CMP_RUN  | comparing slice idx, higher differing slice overrides
// CMP_DONE | one-cycle done pulse; start ignored
module comp_serial_nbit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int N     = WIDTH / 2;
   localparam int IDX_W = idx_width(N);

   cmp_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [2:0]       acc_q,   acc_d;
   logic [2:0]       res_q,   res_d;
   logic [WIDTH-1:0] opa_q,   opa_d;
   logic [WIDTH-1:0] opb_q,   opb_d;

   logic [1:0] slice_a;
   logic [1:0] slice_b;
   logic       cell_eq;
   logic       cell_lt;
   logic       cell_gt;
   logic [2:0] acc_upd;
   logic       last_slice;

   always_comb begin
      slice_a = 2'b00;
      slice_b = 2'b00;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            slice_a = opa_q[2*i +: 2];
            slice_b = opb_q[2*i +: 2];
         end
      end
   end

   comp_cell_2bit u_cell (
      .a  (slice_a),
      .b  (slice_b),
      .eq (cell_eq),
      .lt (cell_lt),
      .gt (cell_gt)
   );

   // A differing slice is more significant than anything seen so far.
   assign acc_upd    = cell_eq ? acc_q : {1'b0, cell_lt, cell_gt};
   assign last_slice = (idx_q == IDX_W'(N - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      res_d   = res_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      case (state_q)
         CMP_IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               acc_d   = ACC_INIT;
               idx_d   = '0;
               state_d = CMP_RUN;
            end
         end
         CMP_RUN: begin
            acc_d = acc_upd;
            if (last_slice) begin
               res_d   = acc_upd;
               state_d = CMP_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         CMP_DONE: begin
            state_d = CMP_IDLE;
         end
         default: begin
            state_d = CMP_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CMP_IDLE;
         idx_q   <= '0;
         acc_q   <= ACC_INIT;
         res_q   <= RES_RST;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
      end
   end

   assign busy = (state_q != CMP_IDLE);
   assign done = (state_q == CMP_DONE);
   assign eq   = res_q[2];
   assign lt   = res_q[1];
   assign gt   = res_q[0];

endmodule

// File: tb/tb_comp_serial_nbit.sv
// Self-checking bench for comp_serial_nbit (WIDTH=8): vector table plus
// hand-written corner sequences, results checked through a scoreboard queue.
module tb_comp_serial_nbit;

   localparam int WIDTH = 8;
   localparam int N     = WIDTH / 2;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             eq;
   logic             lt;
   logic             gt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [2:0] res;
      int         acc;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] res;
   } vec_t;

   exp_t       sb[$];
   exp_t       mon_e;
   vec_t       vecs[10];
   logic [2:0] prev_res;
   int         acc0;

   comp_serial_nbit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .lt    (lt),
      .gt    (gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", 32'({eq, lt, gt}), 32'(mon_e.res));
            check("latency", 32'(cyc - mon_e.acc), 32'(N));
         end
      end
   end

   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] res);
      int bcnt;
      bcnt = 0;
      @(negedge clk);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      sb.push_back('{res, cyc + 1});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         a     = 8'($urandom);
         b     = 8'($urandom);
         if (busy !== 1'b1) break;
         bcnt++;
         if (done !== 1'b1) check("hold", 32'({eq, lt, gt}), 32'(prev_res));
      end
      check("busy_cycles", 32'(bcnt), 32'(N + 1));
      prev_res = res;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'hA5, 8'hA5, 3'b100};
      vecs[1] = '{8'h80, 8'h7F, 3'b001};
      vecs[2] = '{8'h01, 8'h02, 3'b010};
      vecs[3] = '{8'h43, 8'h80, 3'b010};
      vecs[4] = '{8'h00, 8'h00, 3'b100};
      vecs[5] = '{8'hFF, 8'hFE, 3'b001};
      vecs[6] = '{8'h00, 8'hFF, 3'b010};
      vecs[7] = '{8'h7F, 8'h80, 3'b010};
      vecs[8] = '{8'h81, 8'h80, 3'b001};
      vecs[9] = '{8'h42, 8'h41, 3'b001};

      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      prev_res = 3'b000;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'({eq, lt, gt}), 32'd0);
      rst_n = 1'b1;

      for (int v = 0; v < 10; v++) begin
         do_op(vecs[v].a, vecs[v].b, vecs[v].res);
      end

      // start pulses while busy and during DONE are ignored
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20;
      sb.push_back('{3'b010, cyc + 1});
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'h00;
      @(negedge clk);
      start = 1'b0;
      check("hold_midrun", 32'({eq, lt, gt}), 32'(prev_res));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done", 32'(busy), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_requeue", 32'(busy), 32'd0);
      end
      check("hold_lt", 32'({eq, lt, gt}), 32'b010);
      prev_res = 3'b010;

      // reset mid-operation, then reset coincident with start
      @(negedge clk);
      start = 1'b1; a = 8'hF0; b = 8'h0F;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'({eq, lt, gt}), 32'd0);
      start = 1'b1;
      @(negedge clk);
      check("reset_wins", 32'(busy), 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      prev_res = 3'b000;
      do_op(8'h0F, 8'h0F, 3'b100);

      // back-to-back with start held high
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h33;
      acc0 = cyc + 1;
      sb.push_back('{3'b100, acc0});
      sb.push_back('{3'b001, acc0 + N + 2});
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (cyc == acc0) a = 8'h34;
         if (cyc == acc0 + N + 1) check("b2b_gap_idle", 32'(busy), 32'd0);
         if (cyc == acc0 + N + 2) begin
            check("b2b_second_accept", 32'(busy), 32'd1);
            start = 1'b0;
         end
      end
      check("b2b_final", 32'({eq, lt, gt}), 32'b001);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
